// File: rtl/hazard_unit_pkg.sv
// Shared pipeline types: hazard FSM state encoding and forwarding select codes.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_LDSTALL  = 2'd1,
        HZ_PCWAIT   = 2'd2,
        HZ_REDIRECT = 2'd3
    } hz_state_t;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_RF = 2'b00;
    localparam fwd_sel_t FWD_W  = 2'b01;
    localparam fwd_sel_t FWD_M  = 2'b10;

endpackage

// File: rtl/hazard_unit_fwd_sel.sv
// Execute-stage operand bypass select for one source register.
// Combinational; the memory-stage result wins over writeback when both match.
module fwd_sel
    import hazard_unit_pkg::*;
#(
    parameter int RA_W = 4
) (
    input  logic [RA_W-1:0] ra_i,
    input  logic [RA_W-1:0] wa3m_i,
    input  logic [RA_W-1:0] wa3w_i,
    input  logic            reg_write_m_i,
    input  logic            reg_write_w_i,
    output logic [1:0]      sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (reg_write_m_i && (ra_i == wa3m_i)) begin
            sel_o = FWD_M;
        end else if (reg_write_w_i && (ra_i == wa3w_i)) begin
            sel_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: stall/flush/forward decisions are combinational,
// in-flight PC-write tracking, debug FSM and saturating perf counters are registered.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [RA_W-1:0]  RA1D,
    input  logic [RA_W-1:0]  RA2D,
    input  logic [RA_W-1:0]  RA1E,
    input  logic [RA_W-1:0]  RA2E,
    input  logic [RA_W-1:0]  WA3E,
    input  logic [RA_W-1:0]  WA3M,
    input  logic [RA_W-1:0]  WA3W,
    input  logic             MemtoRegE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcD,
    input  logic             PCSrcM,
    input  logic             BranchTakenE,
    output logic             StallF,
    output logic             StallD,
    output logic             FlushD,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic             pcsrc_e_q, pcsrc_e_d;
    logic             pcsrc_w_q;
    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic     ldr_stall, pc_wr_pending;
    logic     stall_f_raw, stall_d_raw, flush_d_raw, flush_e_raw;
    fwd_sel_t fwd_a, fwd_b;

    fwd_sel #(.RA_W(RA_W)) u_fwd_a (
        .ra_i(RA1E), .wa3m_i(WA3M), .wa3w_i(WA3W),
        .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .sel_o(fwd_a)
    );

    fwd_sel #(.RA_W(RA_W)) u_fwd_b (
        .ra_i(RA2E), .wa3m_i(WA3M), .wa3w_i(WA3W),
        .reg_write_m_i(RegWriteM), .reg_write_w_i(RegWriteW), .sel_o(fwd_b)
    );

    assign ldr_stall     = MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E));
    assign pc_wr_pending = PCSrcD || pcsrc_e_q || PCSrcM;

    assign stall_f_raw = ldr_stall || pc_wr_pending;
    assign stall_d_raw = ldr_stall;
    assign flush_d_raw = pc_wr_pending || pcsrc_w_q || BranchTakenE;
    assign flush_e_raw = ldr_stall || BranchTakenE;

    // While reset is held the pipeline is drained: no stalls, both stage registers cleared.
    assign StallF    = reset ? 1'b0 : stall_f_raw;
    assign StallD    = reset ? 1'b0 : stall_d_raw;
    assign FlushD    = reset ? 1'b1 : flush_d_raw;
    assign FlushE    = reset ? 1'b1 : flush_e_raw;
    assign ForwardAE = reset ? FWD_RF : fwd_a;
    assign ForwardBE = reset ? FWD_RF : fwd_b;

    always_comb begin
        pcsrc_e_d = flush_e_raw ? 1'b0 : (stall_d_raw ? pcsrc_e_q : PCSrcD);

        if (BranchTakenE || pcsrc_w_q) begin
            state_d = HZ_REDIRECT;
        end else if (ldr_stall) begin
            state_d = HZ_LDSTALL;
        end else if (pc_wr_pending) begin
            state_d = HZ_PCWAIT;
        end else begin
            state_d = HZ_RUN;
        end

        stall_cnt_d = stall_cnt_q;
        if (stall_f_raw && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end

        // A redirect is counted once, on the edge into REDIRECT.
        flush_cnt_d = flush_cnt_q;
        if ((state_d == HZ_REDIRECT) && (state_q != HZ_REDIRECT)
            && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcsrc_e_q   <= 1'b0;
            pcsrc_w_q   <= 1'b0;
            state_q     <= HZ_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            pcsrc_e_q   <= pcsrc_e_d;
            pcsrc_w_q   <= PCSrcM;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign hz_state  = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Randomised and directed bench for hazard_unit against a cycle-level reference model.
module tb_hazard_unit;

    localparam int RA_W  = 4;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [RA_W-1:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic            MemtoRegE, RegWriteM, RegWriteW, PCSrcD, PCSrcM, BranchTakenE;
    logic            StallF, StallD, FlushD, FlushE;
    logic [1:0]      ForwardAE, ForwardBE, hz_state;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcD(PCSrcD), .PCSrcM(PCSrcM), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .hz_state(hz_state),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: PC write decoded last cycle (not squashed), PC write seen in M
    // last cycle, last cycle's classification and the two event counts.
    bit m_pe, m_pw;
    int m_st, m_sc, m_fc;
    bit warm = 0;
    int n_sf, n_fd;

    function automatic int fwd_ref(input logic [RA_W-1:0] ra);
        if (RegWriteM && ra == WA3M) return 2;
        if (RegWriteW && ra == WA3W) return 1;
        return 0;
    endfunction

    task automatic cycle();
        bit ld, pend, sf, sd, fd, fe;
        int cls;
        @(negedge clk);
        ld   = MemtoRegE && (RA1D == WA3E || RA2D == WA3E);
        pend = PCSrcD || m_pe || PCSrcM;
        sf = ld || pend;
        sd = ld;
        fd = pend || m_pw || BranchTakenE;
        fe = ld || BranchTakenE;
        if (reset) begin
            chk("StallF", StallF, 0);  chk("StallD", StallD, 0);
            chk("FlushD", FlushD, 1);  chk("FlushE", FlushE, 1);
            chk("FwdA", ForwardAE, 0); chk("FwdB", ForwardBE, 0);
        end else begin
            chk("StallF", StallF, sf); chk("StallD", StallD, sd);
            chk("FlushD", FlushD, fd); chk("FlushE", FlushE, fe);
            chk("FwdA", ForwardAE, fwd_ref(RA1E));
            chk("FwdB", ForwardBE, fwd_ref(RA2E));
        end
        if (warm) begin
            chk("hz_state", hz_state, m_st);
            chk("stall_cnt", stall_cnt, m_sc);
            chk("flush_cnt", flush_cnt, m_fc);
        end
        if (StallF) n_sf++;
        if (FlushD) n_fd++;
        cls = (BranchTakenE || m_pw) ? 3 : ld ? 1 : pend ? 2 : 0;
        @(posedge clk);
        if (reset) begin
            m_pe = 0; m_pw = 0; m_st = 0; m_sc = 0; m_fc = 0;
        end else begin
            if (fe) m_pe = 0;
            else if (!sd) m_pe = PCSrcD;
            m_pw = PCSrcM;
            if (sf && m_sc < CMAX) m_sc++;
            if (cls == 3 && m_st != 3 && m_fc < CMAX) m_fc++;
            m_st = cls;
        end
        warm = 1;
        #1;
    endtask

    task automatic idle();
        reset = 0; MemtoRegE = 0; RegWriteM = 0; RegWriteW = 0;
        PCSrcD = 0; PCSrcM = 0; BranchTakenE = 0;
        RA1D = 0; RA2D = 1; RA1E = 2; RA2E = 3; WA3E = 4; WA3M = 5; WA3W = 6;
    endtask

    task automatic do_reset();
        idle(); reset = 1; cycle(); reset = 0;
    endtask

    initial begin
        idle();
        do_reset();
        chk("rst_state", hz_state, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);

        // Load-use on RA1D
        MemtoRegE = 1; WA3E = 2; RA1D = 2; #1;
        chk("t1_StallF", StallF, 1); chk("t1_StallD", StallD, 1); chk("t1_FlushE", FlushE, 1);
        cycle(); idle();
        chk("t1_state", hz_state, 1); chk("t1_stall_cnt", stall_cnt, 1);
        cycle();

        // Forwarding priority
        RegWriteM = 1; WA3M = 5; RegWriteW = 1; WA3W = 5; RA1E = 5; #1;
        chk("t2_fwdM", ForwardAE, 2);
        RegWriteM = 0; #1;
        chk("t2_fwdW", ForwardAE, 1);
        cycle(); idle();

        // PC write travelling down the pipe
        do_reset(); n_sf = 0; n_fd = 0;
        PCSrcD = 1; cycle(); PCSrcD = 0; cycle();
        PCSrcM = 1; cycle(); PCSrcM = 0;
        for (int i = 0; i < 3; i++) cycle();
        chk("t3_stall_cycles", n_sf, 3);
        chk("t3_flushd_cycles", n_fd, 4);
        chk("t3_flush_cnt", flush_cnt, 1);

        // Branch taken coinciding with load-use
        do_reset();
        MemtoRegE = 1; WA3E = 7; RA2D = 7; BranchTakenE = 1; #1;
        chk("t4_StallF", StallF, 1); chk("t4_StallD", StallD, 1);
        chk("t4_FlushD", FlushD, 1); chk("t4_FlushE", FlushE, 1);
        cycle(); idle();
        chk("t4_state", hz_state, 3); chk("t4_flush_cnt", flush_cnt, 1);

        // Counter saturation
        do_reset();
        MemtoRegE = 1; WA3E = 3; RA1D = 3;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) cycle();
        chk("t5_stall_sat", stall_cnt, CMAX);
        idle();

        // Reset while a PC write is pending
        do_reset();
        PCSrcD = 1; cycle(); PCSrcD = 0;
        chk("t6_pcwait", hz_state, 2);
        reset = 1; #1;
        chk("t6_rst_FlushD", FlushD, 1); chk("t6_rst_FlushE", FlushE, 1);
        chk("t6_rst_StallF", StallF, 0); chk("t6_rst_StallD", StallD, 0);
        cycle(); reset = 0; #1;
        chk("t6_post_StallF", StallF, 0);
        chk("t6_post_state", hz_state, 0);
        chk("t6_post_stall_cnt", stall_cnt, 0);
        chk("t6_post_flush_cnt", flush_cnt, 0);
        cycle();

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 39) == 0);
            RA1D         = RA_W'($urandom_range(0, 3));
            RA2D         = RA_W'($urandom_range(0, 3));
            RA1E         = RA_W'($urandom_range(0, 3));
            RA2E         = RA_W'($urandom_range(0, 3));
            WA3E         = RA_W'($urandom_range(0, 3));
            WA3M         = RA_W'($urandom_range(0, 3));
            WA3W         = RA_W'($urandom_range(0, 3));
            MemtoRegE    = ($urandom_range(0, 3) == 0);
            RegWriteM    = $urandom_range(0, 1) == 1;
            RegWriteW    = $urandom_range(0, 1) == 1;
            PCSrcD       = ($urandom_range(0, 7) == 0);
            PCSrcM       = ($urandom_range(0, 7) == 0);
            BranchTakenE = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("%0d/%0d checks passed", n_checks - n_fails, n_checks);
        $finish;
    end

endmodule
